// File: rtl/gray_count_source.sv
// -----------------------------------------------------------------------------
// gray_count_source
//
// Registered Gray-code producer. It keeps an internal binary count and emits
// one Gray code per accepted transfer on a valid/ready output channel. Supports
// up/down counting, synchronous load and a terminal-count sideband. Downstream
// Gray-to-binary conversion of each emitted code should reproduce the binary
// value that `count` held when the code was emitted.
//
// Ports:
//   clk         in   rising-edge clock
//   resetn      in   asynchronous active-low reset
//   en          in   request to emit the next code
//   dir         in   direction applied at emission (1 = up, 0 = down)
//   load        in   synchronous load of load_bin (drops any pending code)
//   load_bin    in   binary value for the next emission after a load
//   gray        out  emitted Gray code (registered)
//   gray_valid  out  gray holds an unconsumed code
//   gray_ready  in   downstream accepts gray this cycle
//   wrap        out  emitted code is the terminal value for its direction
//   count       out  binary value of the next code to emit
// -----------------------------------------------------------------------------
module gray_count_source #(
  parameter int DATA_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_bin,
  output logic [DATA_WIDTH-1:0] gray,
  output logic                  gray_valid,
  input  logic                  gray_ready,
  output logic                  wrap,
  output logic [DATA_WIDTH-1:0] count
);

  localparam logic [DATA_WIDTH-1:0] COUNT_MAX  = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] COUNT_ZERO = {DATA_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] gray_q, gray_d;
  logic                  valid_q, valid_d;
  logic                  wrap_q, wrap_d;

  logic [DATA_WIDTH-1:0] next_gray;
  logic                  fire;
  logic                  slot;

  // Binary-to-Gray of the value about to be emitted: each bit is the XOR of
  // its binary bit and the next more significant one; the MSB passes through.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH - 1; gi++) begin : g_gray_bit
      assign next_gray[gi] = count_q[gi] ^ count_q[gi+1];
    end
  endgenerate
  assign next_gray[DATA_WIDTH-1] = count_q[DATA_WIDTH-1];

  assign fire = valid_q & gray_ready;
  // Output register is empty or being drained at this edge.
  assign slot = ~valid_q | gray_ready;

  always_comb begin
    count_d = count_q;
    gray_d  = gray_q;
    valid_d = valid_q;
    wrap_d  = wrap_q;
    if (load) begin
      // Load discards any pending code; gray/wrap keep their last values.
      count_d = load_bin;
      valid_d = 1'b0;
    end else if (en && slot) begin
      gray_d  = next_gray;
      valid_d = 1'b1;
      wrap_d  = dir ? (count_q == COUNT_MAX) : (count_q == COUNT_ZERO);
      count_d = dir ? (count_q + 1'b1) : (count_q - 1'b1);
    end else if (fire) begin
      // Reaching here with fire set implies en is low (fire implies slot).
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      gray_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      gray_q  <= gray_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign gray       = gray_q;
  assign gray_valid = valid_q;
  assign wrap       = wrap_q;
  assign count      = count_q;

endmodule
